// File: rtl/tag_lookup_unit.sv
// Set-associative tag store with one-cycle registered lookup and refill writes.
// Latency 1 from accept to resp_valid; req_ready drops only while a held response is unconsumed.
module tag_lookup_unit #(
   parameter int TAG_W = 8,
   parameter int IDX_W = 4,
   parameter int WAYS  = 4,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [TAG_W-1:0]         req_tag,
   input  logic [IDX_W-1:0]         req_idx,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic                     resp_hit,
   output logic [$clog2(WAYS)-1:0]  resp_way,
   output logic [IDX_W-1:0]         resp_idx,
   output logic [TAG_W-1:0]         resp_tag,
   input  logic                     fill_valid,
   input  logic [IDX_W-1:0]         fill_idx,
   input  logic [TAG_W-1:0]         fill_tag,
   input  logic                     inv_all,
   output logic [CNT_W-1:0]         hit_count,
   output logic [CNT_W-1:0]         miss_count
);

   localparam int SETS  = 2 ** IDX_W;
   localparam int WAY_W = $clog2(WAYS);

   typedef struct packed {
      logic             hit;
      logic [WAY_W-1:0] way;
   } sel_t;

   logic [WAYS-1:0][TAG_W-1:0] tag_mem [SETS];
   logic [WAYS-1:0]            vld_mem [SETS];
   logic [WAY_W-1:0]           ptr_mem [SETS];

   sel_t lk_sel;
   sel_t fl_sel;
   logic accept;
   logic consume;
   logic fill_full;

   // Lowest hitting way wins, then lowest invalid way, then the set's victim pointer.
   function automatic sel_t pick(input logic [WAYS-1:0][TAG_W-1:0] tags,
                                 input logic [WAYS-1:0]            vld,
                                 input logic [WAY_W-1:0]           ptr,
                                 input logic [TAG_W-1:0]           tag);
      sel_t             s;
      logic             hit_f;
      logic             free_f;
      logic [WAY_W-1:0] hit_w;
      logic [WAY_W-1:0] free_w;
      hit_f  = 1'b0;
      free_f = 1'b0;
      hit_w  = '0;
      free_w = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (vld[w] && (tags[w] == tag)) begin
            hit_f = 1'b1;
            hit_w = WAY_W'(w);
         end
         if (!vld[w]) begin
            free_f = 1'b1;
            free_w = WAY_W'(w);
         end
      end
      s.hit = hit_f;
      s.way = hit_f ? hit_w : (free_f ? free_w : ptr);
      return s;
   endfunction

   assign req_ready = !resp_valid || resp_ready;
   assign accept    = req_valid && req_ready;
   assign consume   = resp_valid && resp_ready;

   assign lk_sel    = pick(tag_mem[req_idx], vld_mem[req_idx], ptr_mem[req_idx], req_tag);
   assign fl_sel    = pick(tag_mem[fill_idx], vld_mem[fill_idx], ptr_mem[fill_idx], fill_tag);
   assign fill_full = &vld_mem[fill_idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SETS; s++) begin
            vld_mem[s] <= '0;
            ptr_mem[s] <= '0;
         end
      end else if (inv_all) begin
         for (int s = 0; s < SETS; s++) begin
            vld_mem[s] <= '0;
            ptr_mem[s] <= '0;
         end
      end else if (fill_valid) begin
         vld_mem[fill_idx][fl_sel.way] <= 1'b1;
         // Only a true replacement of a full set moves the victim pointer.
         if (!fl_sel.hit && fill_full) begin
            ptr_mem[fill_idx] <= fl_sel.way + WAY_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (fill_valid && !inv_all) begin
         tag_mem[fill_idx][fl_sel.way] <= fill_tag;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_valid <= 1'b0;
         resp_hit   <= 1'b0;
         resp_way   <= '0;
         resp_idx   <= '0;
         resp_tag   <= '0;
      end else if (accept) begin
         resp_valid <= 1'b1;
         resp_hit   <= lk_sel.hit;
         resp_way   <= lk_sel.way;
         resp_idx   <= req_idx;
         resp_tag   <= req_tag;
      end else if (resp_ready) begin
         resp_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (consume) begin
         if (resp_hit) begin
            if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
         end else begin
            if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
         end
      end
   end

endmodule
